// File: rtl/reg_bus_pkg.sv
`default_nettype none
// ============================================================================
// Module      : reg_bus_pkg
// Description : Shared FSM state type and address-range helper for the
//               register bus responder.
// Revision    : 1.0 - initial release
// ============================================================================
package reg_bus_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    function automatic logic addr_in_range(input logic [31:0] addr,
                                           input int unsigned num_regs);
        return (addr < num_regs);
    endfunction

endpackage
`default_nettype wire

// File: rtl/reg_rd_mux.sv
`default_nettype none
// ============================================================================
// Module      : reg_rd_mux
// Description : NUM_REGS:1 read mux over the concatenated register outputs;
//               addresses with no matching register read as zero.
// Revision    : 1.0 - initial release
// ============================================================================
module reg_rd_mux #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic [ADDR_WIDTH-1:0]          addr,
    input  logic [NUM_REGS*DATA_WIDTH-1:0] curr_values,
    output logic [DATA_WIDTH-1:0]          rdata
);

    always_comb begin
        rdata = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (addr == ADDR_WIDTH'(i)) begin
                rdata = curr_values[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/reg_bus_slave.sv
`default_nettype none
// ============================================================================
// Module      : reg_bus_slave
// Description : Four-phase req/ack responder that turns host accesses into
//               register update strobes and read-back of register values.
// Revision    : 1.0 - initial release
// ============================================================================
module reg_bus_slave
    import reg_bus_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           req,
    input  logic                           we,
    input  logic [ADDR_WIDTH-1:0]          addr,
    input  logic [DATA_WIDTH-1:0]          wdata,
    output logic                           ack,
    output logic                           err,
    output logic [DATA_WIDTH-1:0]          rdata,
    output logic [NUM_REGS-1:0]            update,
    output logic [DATA_WIDTH-1:0]          new_value,
    input  logic [NUM_REGS*DATA_WIDTH-1:0] curr_values
);

    localparam logic [NUM_REGS-1:0] c_one_hot_base = NUM_REGS'(1);

    state_t                  r_state;
    state_t                  w_next_state;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic                    r_we;
    logic [DATA_WIDTH-1:0]   r_wdata;
    logic                    r_ack;
    logic                    r_err;
    logic [DATA_WIDTH-1:0]   r_rdata;
    logic [NUM_REGS-1:0]     r_update;
    logic [DATA_WIDTH-1:0]   r_new_value;

    logic                    w_latch;
    logic                    w_ack;
    logic                    w_err;
    logic [DATA_WIDTH-1:0]   w_rdata;
    logic [NUM_REGS-1:0]     w_update;
    logic [DATA_WIDTH-1:0]   w_new_value;
    logic                    w_in_range;
    logic [DATA_WIDTH-1:0]   w_mux_data;

    assign w_in_range = addr_in_range(32'(r_addr), NUM_REGS);

    reg_rd_mux #(
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_REGS   (NUM_REGS),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_rd_mux (
        .addr        (r_addr),
        .curr_values (curr_values),
        .rdata       (w_mux_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Request fields are captured once in IDLE; later bus changes are ignored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr  <= '0;
            r_we    <= 1'b0;
            r_wdata <= '0;
        end else if (w_latch) begin
            r_addr  <= addr;
            r_we    <= we;
            r_wdata <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ack       <= 1'b0;
            r_err       <= 1'b0;
            r_rdata     <= '0;
            r_update    <= '0;
            r_new_value <= '0;
        end else begin
            r_ack       <= w_ack;
            r_err       <= w_err;
            r_rdata     <= w_rdata;
            r_update    <= w_update;
            r_new_value <= w_new_value;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_latch      = 1'b0;
        w_ack        = r_ack;
        w_err        = r_err;
        w_rdata      = r_rdata;
        w_new_value  = r_new_value;
        w_update     = '0;
        case (r_state)
            IDLE: begin
                if (req) begin
                    w_latch      = 1'b1;
                    w_next_state = ACCESS;
                end
            end
            ACCESS: begin
                w_next_state = RESP;
                w_ack        = 1'b1;
                w_err        = !w_in_range;
                if (r_we) begin
                    if (w_in_range) begin
                        w_update    = c_one_hot_base << r_addr;
                        w_new_value = r_wdata;
                    end
                end else begin
                    // Mux already yields zero for out-of-range addresses.
                    w_rdata = w_mux_data;
                end
            end
            RESP: begin
                if (!req) begin
                    w_ack        = 1'b0;
                    w_err        = 1'b0;
                    w_next_state = IDLE;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    assign ack       = r_ack;
    assign err       = r_err;
    assign rdata     = r_rdata;
    assign update    = r_update;
    assign new_value = r_new_value;

endmodule
`default_nettype wire

// File: tb/tb_reg_bus_slave.sv
`default_nettype none
// ============================================================================
// Module      : tb_reg_bus_slave
// Description : Self-checking bench for reg_bus_slave with a register bank
//               model, a cycle-level reference model and directed accesses.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_bus_slave;

    localparam int DW = 32;
    localparam int NR = 8;
    localparam int AW = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             req = 1'b0;
    logic             we = 1'b0;
    logic [AW-1:0]    addr = '0;
    logic [DW-1:0]    wdata = '0;
    logic             ack;
    logic             err;
    logic [DW-1:0]    rdata;
    logic [NR-1:0]    update;
    logic [DW-1:0]    new_value;
    logic [NR*DW-1:0] curr_values;

    int   checks = 0;
    int   errors = 0;
    logic bank_init = 1'b1;
    logic chk_en = 1'b0;

    always #5 clk = ~clk;

    reg_bus_slave #(
        .DATA_WIDTH (DW),
        .NUM_REGS   (NR),
        .ADDR_WIDTH (AW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req),
        .we          (we),
        .addr        (addr),
        .wdata       (wdata),
        .ack         (ack),
        .err         (err),
        .rdata       (rdata),
        .update      (update),
        .new_value   (new_value),
        .curr_values (curr_values)
    );

    function automatic logic [DW-1:0] def_val(input int i);
        return (i == 0) ? 32'h0000_1234 : (32'hD00D_0000 | 32'(i));
    endfunction

    // Register bank outside the DUT: loads new_value on its update bit.
    logic [DW-1:0] bank [NR];
    always @(posedge clk) begin
        for (int i = 0; i < NR; i++) begin
            if (bank_init) bank[i] <= def_val(i);
            else if (update[i]) bank[i] <= new_value;
        end
    end

    for (genvar g = 0; g < NR; g++) begin : g_cv
        assign curr_values[g*DW +: DW] = bank[g];
    end

    task automatic cmp(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, got, exp);
        end
    endtask

    // Reference model: accept when idle, respond one edge later, release on req low.
    logic          m_busy;
    int            m_age;
    int            m_addr;
    logic          m_we;
    logic [DW-1:0] m_wdata;
    logic          m_ack;
    logic          m_err;
    logic [DW-1:0] m_rdata;
    logic [NR-1:0] m_update;
    logic [DW-1:0] m_new_value;
    logic [DW-1:0] m_mem [NR];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy <= 1'b0; m_age <= 0; m_addr <= 0; m_we <= 1'b0; m_wdata <= '0;
            m_ack <= 1'b0; m_err <= 1'b0; m_rdata <= '0;
            m_update <= '0; m_new_value <= '0;
            if (bank_init) for (int i = 0; i < NR; i++) m_mem[i] <= def_val(i);
        end else begin
            m_update <= '0;
            if (!m_busy) begin
                if (req) begin
                    m_busy <= 1'b1; m_age <= 1;
                    m_addr <= int'(addr); m_we <= we; m_wdata <= wdata;
                end
            end else if (m_age == 1) begin
                m_age <= 2;
                m_ack <= 1'b1;
                m_err <= (m_addr >= NR);
                if (m_we && m_addr < NR) begin
                    m_update       <= NR'(1) << m_addr;
                    m_new_value    <= m_wdata;
                    m_mem[m_addr]  <= m_wdata;
                end else if (!m_we) begin
                    m_rdata <= (m_addr < NR) ? m_mem[m_addr] : '0;
                end
            end else if (!req) begin
                m_busy <= 1'b0; m_ack <= 1'b0; m_err <= 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            cmp("model_ack", 32'(ack), 32'(m_ack));
            cmp("model_err", 32'(err), 32'(m_err));
            cmp("model_update", 32'(update), 32'(m_update));
            cmp("model_new_value", new_value, m_new_value);
            cmp("model_rdata", rdata, m_rdata);
        end
    end

    logic [DW-1:0] t_rdata;
    logic          t_err;
    logic [NR-1:0] t_upd_at_ack;
    logic [DW-1:0] t_nv;
    int            t_upd_cnt;
    int            t_cycles;

    // Call on a falling edge; returns on the falling edge where ack has dropped.
    task automatic txn(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d, input int hold);
        bit got = 0;
        t_upd_cnt = 0; t_cycles = 0; t_upd_at_ack = '0; t_nv = '0; t_rdata = '0; t_err = 1'b0;
        req = 1'b1; we = w; addr = a; wdata = d;
        for (int n = 0; n < 8 && !got; n++) begin
            @(negedge clk);
            t_cycles++;
            if (update != '0) t_upd_cnt++;
            addr = ~a; wdata = ~d; we = ~w;
            if (ack) begin
                got = 1;
                t_rdata = rdata; t_err = err; t_upd_at_ack = update; t_nv = new_value;
            end
        end
        if (!got) begin
            checks++; errors++;
            $display("FAIL ack_timeout at %0t: got ack=0 expected ack=1 within 8 cycles", $time);
        end
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            t_cycles++;
            if (update != '0) t_upd_cnt++;
            cmp("ack_held", 32'(ack), 32'd1);
        end
        req = 1'b0;
        @(negedge clk);
        t_cycles++;
        if (update != '0) t_upd_cnt++;
        cmp("ack_fall", 32'(ack), 32'd0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        bank_init = 1'b0;
        rst_n = 1'b1;
        chk_en = 1'b1;
        cmp("rst_ack", 32'(ack), 32'd0);
        cmp("rst_err", 32'(err), 32'd0);
        cmp("rst_update", 32'(update), 32'd0);
        cmp("rst_rdata", rdata, 32'd0);
        cmp("rst_new_value", new_value, 32'd0);

        txn(1'b0, 4'd0, 32'h0, 0);
        cmp("rd0_data", t_rdata, 32'h0000_1234);
        cmp("rd0_err", 32'(t_err), 32'd0);

        txn(1'b1, 4'd3, 32'hA5A5_0003, 0);
        cmp("wr3_update", 32'(t_upd_at_ack), 32'h0000_0008);
        cmp("wr3_new_value", t_nv, 32'hA5A5_0003);
        cmp("wr3_err", 32'(t_err), 32'd0);
        cmp("wr3_pulses", 32'(t_upd_cnt), 32'd1);
        cmp("wr3_cycles", 32'(t_cycles), 32'd3);

        txn(1'b0, 4'd3, 32'h0, 0);
        cmp("rd3_data", t_rdata, 32'hA5A5_0003);

        txn(1'b1, 4'd9, 32'h9999_9999, 0);
        cmp("wr9_err", 32'(t_err), 32'd1);
        cmp("wr9_pulses", 32'(t_upd_cnt), 32'd0);

        txn(1'b0, 4'd15, 32'h0, 0);
        cmp("rd15_err", 32'(t_err), 32'd1);
        cmp("rd15_data", t_rdata, 32'h0);

        txn(1'b1, 4'd6, 32'h6666_0006, 5);
        cmp("held_pulses", 32'(t_upd_cnt), 32'd1);
        cmp("held_cycles", 32'(t_cycles), 32'd8);
        txn(1'b0, 4'd6, 32'h0, 0);
        cmp("held_next_cycles", 32'(t_cycles), 32'd3);
        cmp("held_rd_data", t_rdata, 32'h6666_0006);

        // Abort a write while it is in its access cycle.
        req = 1'b1; we = 1'b1; addr = 4'd5; wdata = 32'hDEAD_BEEF;
        @(negedge clk);
        rst_n = 1'b0; req = 1'b0;
        #1;
        cmp("abort_ack", 32'(ack), 32'd0);
        cmp("abort_err", 32'(err), 32'd0);
        cmp("abort_update", 32'(update), 32'd0);
        cmp("abort_rdata", rdata, 32'd0);
        cmp("abort_new_value", new_value, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            cmp("abort_no_update", 32'(update), 32'd0);
            cmp("abort_no_ack", 32'(ack), 32'd0);
        end
        txn(1'b0, 4'd5, 32'h0, 0);
        cmp("abort_rd5_data", t_rdata, 32'hD00D_0005);
        cmp("abort_rd5_cycles", 32'(t_cycles), 32'd3);

        for (int i = 0; i < NR; i++) begin
            txn(1'b1, AW'(i), 32'hC0DE_0000 | 32'(i), 0);
            cmp("b2b_wr_cycles", 32'(t_cycles), 32'd3);
            cmp("b2b_wr_pulses", 32'(t_upd_cnt), 32'd1);
            txn(1'b0, AW'(i), 32'h0, 0);
            cmp("b2b_rd_cycles", 32'(t_cycles), 32'd3);
            cmp("b2b_rd_data", t_rdata, 32'hC0DE_0000 | 32'(i));
        end

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog at %0t: got no completion expected finish", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/reg_bus_slave.md
# reg_bus_slave

Bus-side responder for a bank of `register` instances. It accepts single read/write requests from a host over a four-phase req/ack handshake. Writes are decoded into a one-cycle `update` strobe plus a shared `new_value` for the addressed register. Reads return the addressed register's `curr_value`. It sits between the host interconnect and the register bank, as the access end of each register's `update`/`new_value`/`curr_value` interface.

## Interface
- `DATA_WIDTH`, default 32: width of each register and of the bus data.
- `NUM_REGS`, default 8: number of registers in the bank, indices 0..NUM_REGS-1.
- `ADDR_WIDTH`, default 4: word address width. Must satisfy 2**ADDR_WIDTH >= NUM_REGS.
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req`  in  1  host request; held high until `ack` is seen, then dropped.
- `we`  in  1  1 = write, 0 = read; valid while `req` is high.
- `addr`  in  ADDR_WIDTH  word index of the target register.
- `wdata`  in  DATA_WIDTH  write data.
- `ack`  out  1  response valid; held until `req` is low.
- `err`  out  1  address out of range; valid while `ack` is high.
- `rdata`  out  DATA_WIDTH  read data; valid while `ack` is high.
- `update`  out  NUM_REGS  one-hot write strobe, one bit per register.
- `new_value`  out  DATA_WIDTH  shared write data to all registers.
- `curr_values`  in  NUM_REGS*DATA_WIDTH  concatenated register outputs; register i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].

## Operation
- FSM states: IDLE, ACCESS, RESP.
- **IDLE:** if `req`=1, latch `addr`, `we` and `wdata`, then go to ACCESS. Otherwise stay in IDLE.
- **ACCESS:** lasts exactly one cycle and always goes to RESP. On the exit edge the block:
  - sets `ack` to 1;
  - sets `err` to 1 if the latched address >= NUM_REGS;
  - for a write with a valid address, sets `update` to the one-hot bit of the address and `new_value` to the latched wdata;
  - for a read with a valid address, sets `rdata` to the addressed slice of `curr_values`;
  - for a read with an invalid address, sets `rdata` to 0;
  - for a write with an invalid address, leaves `update` at 0.
- **RESP:**
  - `update` clears after one cycle.
  - `ack`, `err` and `rdata` hold while `req`=1.
  - When `req`=0 is sampled: `ack`=0, `err`=0, go to IDLE.
- `new_value` and `rdata` hold their last values outside responses. Consumers qualify them with `update` and `ack` respectively.
- The block never reads back a value it has just written. If a register's `default_value` differs, the read returns the register's actual `curr_value`.
- Changes to `addr`/`we`/`wdata` after the IDLE sample are ignored.
- **Reset:** `ack`=0, `err`=0, `update`=0, `rdata`=0, `new_value`=0, state=IDLE. This applies immediately, including mid-transaction. An aborted transaction produces no further `update` pulse and no `ack`.

## Timing
- Edge E0: `req` sampled high in IDLE.
- Edge E1: `ack`, `err` and `rdata` become valid; for writes, `update` goes high.
- Edge E2: `update` falls. The target register loads `new_value` at E2.
- `update` is high for exactly one cycle per valid write. It is never asserted on reads or on error.
- `ack` falls on the first edge that samples `req`=0 in RESP. The earliest next acceptance is the edge after that.
- Minimum transaction: 3 cycles from `req` rise to IDLE, when `req` drops the cycle `ack` is first visible.
- Read-after-write: a read accepted after the write's `ack` handshake returns the new value.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Package `reg_bus_pkg` contains:
  - the state enum {IDLE, ACCESS, RESP};
  - a helper function for address-in-range.
- Sub-module `reg_rd_mux`: a combinational NUM_REGS:1 mux of `curr_values` by address, outputting 0 for out-of-range addresses. It is instantiated once.
- Register instances stay outside this block; the integration level wires `update[i]`, `new_value` and `curr_values` to them.

## Test plan
- **Write:** NUM_REGS=8, write addr 3, wdata 0xA5A5_0003 -> `update`=8'b0000_1000 for exactly one cycle at E1, `new_value`=0xA5A5_0003, `ack`=1, `err`=0.
- **Read-back:** read addr 3 after the write -> `rdata`=0xA5A5_0003 with `ack`=1. Read addr 0 with the register held at 0x1234 -> `rdata`=0x0000_1234.
- **Out of range:** write addr 9 -> `err`=1, `ack`=1, `update` stays 0 for the whole transaction. Read addr 15 -> `rdata`=0, `err`=1.
- **Held request:** hold `req` high 5 cycles after `ack` -> `ack` stays 1, only one `update` pulse occurs, no second transaction. Drop `req` -> `ack`=0 on the next edge; a new `req` is accepted the edge after.
- **Reset mid-transaction:** assert `rst_n`=0 during ACCESS of a write -> all outputs 0 immediately, no `update` pulse after reset release, state IDLE. After reset release, the first `req` completes normally.
- **Back-to-back:** alternate write/read to addrs 0..7 with `req` re-asserted as soon as `ack` falls -> every read returns the preceding write's data, each transaction takes 3 cycles.
